// File: rtl/rle_plane_decoder.sv
// rtl/rle_plane_decoder.sv - run-length token stream to packed planar byte words
//
// Expands a stream of 16-bit RLE tokens ({run[15:8], value[7:0]}) read from
// word-addressed memory into consecutive 16-bit output words starting at word 0.
// Two bytes are packed per output word, with the first byte in [7:0]. Decoding
// stops after width*height*3 bytes (19-bit wrap). A trailing odd byte is padded
// with 8'h00 in the high half.
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-low reset
//   start     one-cycle pulse, accepted in IDLE or DONE only
//   width     image width in pixels, sampled on accepted start
//   height    image height in pixels, sampled on accepted start
//   src_base  word address of the first token, sampled on accepted start
//   r_addr    token read address; the RAM returns data one cycle later
//   r_data    token {run, value}
//   w_addr    output word address
//   wdata     packed output word {second byte, first byte}
//   wr_en     one-cycle write strobe per output word
//   busy      decode in progress
//   done      decode finished; held until the next accepted start
module rle_plane_decoder #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [ADDR_W-1:0] src_base,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EMIT  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [18:0]       tot_q;
    logic [18:0]       byte_cnt_q;
    logic [ADDR_W-1:0] tok_ptr_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [7:0]        run_q;
    logic [7:0]        val_q;
    logic [7:0]        low_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_en_q;

    logic [31:0]       area;
    logic [18:0]       tot_calc;
    logic              start_accept;
    logic [18:0]       byte_cnt_inc;
    logic              last_byte;

    // 3*area mod 2^19 computed as area + 2*area on the low 19 bits only.
    assign area         = width * height;
    assign tot_calc     = area[18:0] + {area[17:0], 1'b0};
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign byte_cnt_inc = byte_cnt_q + 19'd1;
    assign last_byte    = (byte_cnt_inc == tot_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (tot_calc == 19'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // A zero-length run carries no bytes; go straight to the next token.
                state_d = (r_data[15:8] == 8'd0) ? S_FETCH : S_EMIT;
            end
            S_EMIT: begin
                // Reaching the byte total wins over run exhaustion, so the
                // token following a run that ends exactly on the total is never read.
                if (last_byte) begin
                    state_d = tot_q[0] ? S_FLUSH : S_DONE;
                end else if (run_q == 8'd1) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tot_q      <= '0;
            byte_cnt_q <= '0;
            tok_ptr_q  <= '0;
            r_addr_q   <= '0;
            run_q      <= '0;
            val_q      <= '0;
            low_q      <= '0;
            w_addr_q   <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;

            // The write address is held during the strobe cycle and advances after it.
            if (wr_en_q) begin
                w_addr_q <= w_addr_q + 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_accept) begin
                        tot_q      <= tot_calc;
                        tok_ptr_q  <= src_base;
                        byte_cnt_q <= '0;
                        w_addr_q   <= '0;
                        low_q      <= '0;
                    end
                end
                S_FETCH: begin
                    r_addr_q <= tok_ptr_q;
                end
                S_LATCH: begin
                    run_q     <= r_data[15:8];
                    val_q     <= r_data[7:0];
                    tok_ptr_q <= tok_ptr_q + 1'b1;
                end
                S_EMIT: begin
                    byte_cnt_q <= byte_cnt_inc;
                    run_q      <= run_q - 8'd1;
                    if (!byte_cnt_q[0]) begin
                        low_q <= val_q;
                    end else begin
                        wdata_q <= {val_q, low_q};
                        wr_en_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    wdata_q <= {8'h00, low_q};
                    wr_en_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output logic. The read address is presented combinationally in FETCH so the
    // synchronous RAM returns the token during LATCH; it holds its last value otherwise.
    always_comb begin
        r_addr = (state_q == S_FETCH) ? tok_ptr_q : r_addr_q;
        busy   = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                 (state_q == S_EMIT)  || (state_q == S_FLUSH);
        done   = (state_q == S_DONE);
        w_addr = w_addr_q;
        wdata  = wdata_q;
        wr_en  = wr_en_q;
    end

endmodule

// File: tb/tb_rle_plane_decoder.sv
// tb/tb_rle_plane_decoder.sv - scoreboard bench for rle_plane_decoder
module tb_rle_plane_decoder;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   width = '0;
    logic [15:0]   height = '0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] wdata;
    logic          wr_en;
    logic          busy;
    logic          done;

    rle_plane_decoder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .width    (width),
        .height   (height),
        .src_base (src_base),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .w_addr   (w_addr),
        .wdata    (wdata),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    always @(posedge clk) r_data <= mem[r_addr[9:0]];

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [AW+DW-1:0] exp_q [$];
    logic [15:0]      tok_q [$];
    logic [AW+DW-1:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && wr_en) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", w_addr, wdata);
            end else begin
                exp_e = exp_q.pop_front();
                if ({w_addr, wdata} !== exp_e) begin
                    failures++;
                    $display("FAIL write_data: got addr %0h data %0h expected addr %0h data %0h",
                             w_addr, wdata, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
                end
            end
        end
    end

    // Reference model: expand tokens into a byte list, cut at the total, pack pairs.
    task automatic prepare(input logic [15:0] w, input logic [15:0] h, input logic [AW-1:0] base,
                           output int tot, output int ntok);
        byte unsigned bytes [$];
        longint t;
        t = (longint'(w) * longint'(h) * 3) % (longint'(1) << 19);
        tot = int'(t);
        ntok = 0;
        for (int i = 0; i < tok_q.size(); i++) begin
            mem[(int'(base) + i) % 1024] = tok_q[i];
        end
        for (int i = 0; i < tok_q.size() && bytes.size() < tot; i++) begin
            ntok++;
            for (int k = 0; k < int'(tok_q[i][15:8]) && bytes.size() < tot; k++) begin
                bytes.push_back(tok_q[i][7:0]);
            end
        end
        for (int i = 0; i < tot; i += 2) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = bytes[i];
            hi = (i + 1 < tot) ? bytes[i+1] : 8'h00;
            exp_q.push_back({AW'(i / 2), hi, lo});
        end
    endtask

    task automatic pulse_start(input logic [15:0] w, input logic [15:0] h, input logic [AW-1:0] base);
        @(negedge clk);
        width = w;
        height = h;
        src_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        width = 16'($urandom);
        height = 16'($urandom);
        src_base = AW'($urandom);
    endtask

    task automatic run_case(input string tag, input logic [15:0] w, input logic [15:0] h,
                            input logic [AW-1:0] base, input bit mid_start);
        int tot;
        int ntok;
        int cyc;
        int wr0;
        int bound;
        logic [AW-1:0] prev_raddr;
        prepare(w, h, base, tot, ntok);
        prev_raddr = r_addr;
        wr0 = wr_count;
        bound = 4 * (tot + tok_q.size()) + 20;
        pulse_start(w, h, base);
        if (tot != 0) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        else check({tag, "_degenerate_done"}, {31'd0, done}, 32'd1);
        cyc = 0;
        while (!done && cyc < bound) begin
            if (mid_start && cyc == 2 && busy) begin
                start = 1'b1;
                width = 16'd3;
                height = 16'd3;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        exp_q.delete();
        check({tag, "_wcount"}, wr_count - wr0, (tot + 1) / 2);
        check({tag, "_waddr"}, {14'd0, w_addr}, 32'((tot + 1) / 2) & 32'h3FFFF);
        check({tag, "_raddr"}, {14'd0, r_addr},
              (ntok > 0) ? ((32'(base) + 32'(ntok) - 1) & 32'h3FFFF) : {14'd0, prev_raddr});
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int wr0;
        int cyc;
        int sum;
        logic [15:0] rw;
        logic [15:0] rh;
        int tot;
        int ntok;
        for (int i = 0; i < 1024; i++) mem[i] = 16'hE0E0;
        repeat (2) @(negedge clk);
        check("reset_raddr", {14'd0, r_addr}, 32'd0);
        check("reset_waddr", {14'd0, w_addr}, 32'd0);
        check("reset_flags", {29'd0, wr_en, busy, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        tok_q = '{16'h05AA, 16'h07BB, 16'hEEEE};
        run_case("t1_basic", 16'd2, 16'd2, 18'd40, 1'b0);
        tok_q = '{16'hFF11, 16'h0533};
        run_case("t2_trunc", 16'd2, 16'd2, 18'd100, 1'b0);
        tok_q = '{16'h0099, 16'h0622, 16'h0177};
        run_case("t3_zero", 16'd1, 16'd2, 18'd200, 1'b0);
        tok_q = '{16'h0342, 16'h0155};
        run_case("t4_odd", 16'd1, 16'd1, 18'd300, 1'b0);
        tok_q = '{16'h0566};
        run_case("t5_degen", 16'd0, 16'd7, 18'd500, 1'b0);

        // Reset in the middle of emitting test 1, then rerun it.
        tok_q = '{16'h05AA, 16'h07BB, 16'hEEEE};
        prepare(16'd2, 16'd2, 18'd40, tot, ntok);
        wr0 = wr_count;
        pulse_start(16'd2, 16'd2, 18'd40);
        cyc = 0;
        while (wr_count - wr0 < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_emit", {31'd0, (wr_count - wr0 >= 2)}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_addrs", {r_addr, 14'd0} | {14'd0, w_addr}, 32'd0);
        check("t6_rst_data", {16'd0, wdata}, 32'd0);
        check("t6_rst_flags", {29'd0, wr_en, busy, done}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t6_rst_hold", {29'd0, wr_en, busy, done}, 32'd0);
        rst = 1'b1;
        wr0 = wr_count;
        repeat (3) @(negedge clk);
        check("t6_no_write_after_rst", wr_count - wr0, 32'd0);
        run_case("t6_rerun", 16'd2, 16'd2, 18'd40, 1'b1);

        for (int n = 0; n < 14; n++) begin
            rw = 16'($urandom_range(0, 5));
            rh = 16'($urandom_range(0, 4));
            tok_q.delete();
            sum = 0;
            while (sum < int'(rw) * int'(rh) * 3 && tok_q.size() < 200) begin
                logic [7:0] run;
                run = ($urandom_range(0, 4) == 0) ? 8'd0 :
                      ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(1, 9));
                tok_q.push_back({run, 8'($urandom)});
                sum += int'(run);
            end
            repeat (3) tok_q.push_back(16'($urandom));
            run_case($sformatf("rnd%0d", n), rw, rh, AW'($urandom_range(0, 900)), n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
